memory_adapter: RTL and testbench

Serialises word, halfword and byte memory transactions onto the CPU's single 8-bit RAM/IO port. It sits directly downstream of the memory operator, which feeds its `ma_*` request port, and of the instruction fetcher, which feeds its `if_*` request port. The block arbitrates between the two, issues one byte address per cycle, and reassembles read data little-endian. It returns a one-cycle done pulse per completed request.

---
 rtl/memory_adapter.sv | 186 ++++++++++++++++++
 tb/tb_memory_adapter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_adapter.sv
// Byte-serial adapter between the memory operator / instruction fetcher and the
// single 8-bit RAM/IO port: arbitrates, walks byte addresses, reassembles reads LE.
module memory_adapter (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush_pipline,
   input  logic        ma_have_mem_access_task,
   input  logic [31:0] ma_mem_access_addr,
   input  logic        ma_mem_access_rw,
   input  logic [1:0]  ma_mem_access_size,
   input  logic [31:0] ma_mem_access_data,
   output logic        ma_mem_access_task_done,
   output logic [31:0] ma_mem_access_data_out,
   input  logic        if_have_fetch_task,
   input  logic [31:0] if_fetch_addr,
   output logic        if_fetch_done,
   output logic [31:0] if_fetch_data,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   function automatic logic [1:0] last_index(input logic [1:0] size);
      case (size)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = word;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

   state_t      state;
   logic [1:0]  k;
   logic [1:0]  last_k;
   logic [31:0] base;
   logic [31:0] wdata;
   logic [31:0] result;
   logic        src_if;
   logic        issuing;
   logic        rd_vld_p1;
   logic [1:0]  rd_k_p1;
   logic        wr_q;

   logic        io_stall;
   logic [1:0]  k_inc;
   logic [31:0] res_next;

   // A write into IO space while the UART buffer is full is held off this cycle
   // and retried; rdy_in low also suppresses the strobe, so both gate it here.
   assign io_stall = (state == WRITE) && wr_q && io_buffer_full && (mem_a >= 32'h0003_0000);
   assign mem_wr   = wr_q && rdy_in && !io_stall;
   assign k_inc    = k + 2'd1;
   assign res_next = put_byte(result, rd_k_p1, mem_din);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state                   <= IDLE;
         k                       <= 2'd0;
         last_k                  <= 2'd0;
         base                    <= 32'd0;
         wdata                   <= 32'd0;
         result                  <= 32'd0;
         src_if                  <= 1'b0;
         issuing                 <= 1'b0;
         rd_vld_p1               <= 1'b0;
         rd_k_p1                 <= 2'd0;
         wr_q                    <= 1'b0;
         mem_a                   <= 32'd0;
         mem_dout                <= 8'd0;
         ma_mem_access_task_done <= 1'b0;
         ma_mem_access_data_out  <= 32'd0;
         if_fetch_done           <= 1'b0;
         if_fetch_data           <= 32'd0;
      end else if (!rdy_in) begin
         // The byte due on mem_din this cycle is lost: rewind to re-present its address.
         if (state == READ && rd_vld_p1) begin
            mem_a     <= base + {30'd0, rd_k_p1};
            k         <= rd_k_p1;
            issuing   <= 1'b1;
            rd_vld_p1 <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (ma_have_mem_access_task) begin
                  base      <= ma_mem_access_addr;
                  wdata     <= ma_mem_access_data;
                  last_k    <= last_index(ma_mem_access_size);
                  src_if    <= 1'b0;
                  result    <= 32'd0;
                  k         <= 2'd0;
                  rd_vld_p1 <= 1'b0;
                  mem_a     <= ma_mem_access_addr;
                  if (ma_mem_access_rw) begin
                     state    <= WRITE;
                     mem_dout <= ma_mem_access_data[7:0];
                     wr_q     <= 1'b1;
                     issuing  <= 1'b0;
                  end else begin
                     state   <= READ;
                     issuing <= 1'b1;
                  end
               end else if (if_have_fetch_task && !flush_pipline) begin
                  base      <= if_fetch_addr;
                  last_k    <= 2'd3;
                  src_if    <= 1'b1;
                  result    <= 32'd0;
                  k         <= 2'd0;
                  rd_vld_p1 <= 1'b0;
                  issuing   <= 1'b1;
                  mem_a     <= if_fetch_addr;
                  state     <= READ;
               end
            end
            READ: begin
               if (flush_pipline) begin
                  state     <= IDLE;
                  issuing   <= 1'b0;
                  rd_vld_p1 <= 1'b0;
                  k         <= 2'd0;
               end else begin
                  // Capture stage: mem_din carries the byte addressed last cycle.
                  if (rd_vld_p1)
                     result <= res_next;
                  if (issuing) begin
                     rd_vld_p1 <= 1'b1;
                     rd_k_p1   <= k;
                     if (k == last_k) begin
                        issuing <= 1'b0;
                     end else begin
                        k     <= k_inc;
                        mem_a <= base + {30'd0, k_inc};
                     end
                  end else begin
                     rd_vld_p1 <= 1'b0;
                  end
                  if (rd_vld_p1 && rd_k_p1 == last_k) begin
                     state <= DONE;
                     if (src_if) begin
                        if_fetch_done <= 1'b1;
                        if_fetch_data <= res_next;
                     end else begin
                        ma_mem_access_task_done <= 1'b1;
                        ma_mem_access_data_out  <= res_next;
                     end
                  end
               end
            end
            WRITE: begin
               if (!io_stall) begin
                  if (k == last_k) begin
                     state                   <= DONE;
                     wr_q                    <= 1'b0;
                     ma_mem_access_task_done <= 1'b1;
                     ma_mem_access_data_out  <= result;
                  end else begin
                     k        <= k_inc;
                     mem_a    <= base + {30'd0, k_inc};
                     mem_dout <= wdata[{k_inc, 3'b000} +: 8];
                  end
               end
            end
            DONE: begin
               ma_mem_access_task_done <= 1'b0;
               if_fetch_done           <= 1'b0;
               k                       <= 2'd0;
               state                   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_adapter.sv
// Randomised self-checking bench for memory_adapter against a byte-array memory
// model and a per-transaction reference of addresses, data and latency.
module tb_memory_adapter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, flush_pipline;
   logic        ma_have_mem_access_task;
   logic [31:0] ma_mem_access_addr;
   logic        ma_mem_access_rw;
   logic [1:0]  ma_mem_access_size;
   logic [31:0] ma_mem_access_data;
   logic        ma_mem_access_task_done;
   logic [31:0] ma_mem_access_data_out;
   logic        if_have_fetch_task;
   logic [31:0] if_fetch_addr;
   logic        if_fetch_done;
   logic [31:0] if_fetch_data;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ram     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic [31:0] wr_a_q[$];
   logic [7:0]  wr_d_q[$];
   logic [31:0] tr_a[$];
   logic        tr_wr[$];
   logic        done_after;

   memory_adapter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
      .ma_have_mem_access_task(ma_have_mem_access_task), .ma_mem_access_addr(ma_mem_access_addr),
      .ma_mem_access_rw(ma_mem_access_rw), .ma_mem_access_size(ma_mem_access_size),
      .ma_mem_access_data(ma_mem_access_data), .ma_mem_access_task_done(ma_mem_access_task_done),
      .ma_mem_access_data_out(ma_mem_access_data_out), .if_have_fetch_task(if_have_fetch_task),
      .if_fetch_addr(if_fetch_addr), .if_fetch_done(if_fetch_done), .if_fetch_data(if_fetch_data),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   // RAM: one-cycle read latency; writes are logged and committed by the main flow.
   always @(posedge clk_in) begin
      if (mem_wr) begin
         wr_a_q.push_back(mem_a);
         wr_d_q.push_back(mem_dout);
      end
      mem_din <= ram[mem_a[15:0]];
   end

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] v, ai;
      v = 32'd0;
      for (int i = 0; i < nbytes(sz); i++) begin
         ai = a + i;
         v  = v | (32'(ref_mem[ai[15:0]]) << (8 * i));
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic commit_writes();
      for (int i = 0; i < wr_a_q.size(); i++) ram[wr_a_q[i][15:0]] = wr_d_q[i];
   endtask

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] ai, sh;
      for (int i = 0; i < nbytes(sz); i++) begin
         ai = a + i;
         sh = d >> (8 * i);
         ref_mem[ai[15:0]] = sh[7:0];
      end
   endtask

   task automatic do_ma(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                        input logic [31:0] d, output int lat, output logic [31:0] rd);
      tr_a.delete(); tr_wr.delete(); wr_a_q.delete(); wr_d_q.delete();
      ma_have_mem_access_task = 1'b1;
      ma_mem_access_addr = a; ma_mem_access_rw = rw;
      ma_mem_access_size = sz; ma_mem_access_data = d;
      lat = -1; rd = 32'd0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         tr_a.push_back(mem_a);
         tr_wr.push_back(mem_wr);
         if (ma_mem_access_task_done) begin
            lat = c; rd = ma_mem_access_data_out;
            break;
         end
      end
      ma_have_mem_access_task = 1'b0;
      tick();
      done_after = ma_mem_access_task_done;
      commit_writes();
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      tick(); tick();
      checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
      checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
      checks++; if (ma_mem_access_task_done !== 1'b0) begin errors++; $display("FAIL reset_ma_done got %b want 0", ma_mem_access_task_done); end
      checks++; if (if_fetch_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b want 0", if_fetch_done); end
      checks++; if (ma_mem_access_data_out !== 32'd0) begin errors++; $display("FAIL reset_ma_data got %h want 0", ma_mem_access_data_out); end
      checks++; if (if_fetch_data !== 32'd0) begin errors++; $display("FAIL reset_if_data got %h want 0", if_fetch_data); end
      rst_in = 1'b0;
      tick();
   endtask

   task automatic test_lw();
      int lat; logic [31:0] rd;
      ram[16'h100] = 8'h11; ram[16'h101] = 8'h22; ram[16'h102] = 8'h33; ram[16'h103] = 8'h44;
      ref_mem[16'h100] = 8'h11; ref_mem[16'h101] = 8'h22; ref_mem[16'h102] = 8'h33; ref_mem[16'h103] = 8'h44;
      do_ma(32'h100, 1'b0, 2'b10, 32'd0, lat, rd);
      checks++; if (lat != 6) begin errors++; $display("FAIL lw_latency got %0d want 6", lat); end
      checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL lw_data got %h want 44332211", rd); end
      checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL lw_pulse_width done still %b after one cycle", done_after); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tr_a.size() <= i || tr_a[i] !== 32'h100 + i || tr_wr[i] !== 1'b0) begin
            errors++;
            $display("FAIL lw_addr cycle %0d got %h want %h", i + 1, (tr_a.size() > i) ? tr_a[i] : 32'hx, 32'h100 + i);
         end
      end
   endtask

   task automatic test_sh();
      int lat; logic [31:0] rd;
      ram[16'h204] = 8'h77; ref_mem[16'h204] = 8'h77;
      do_ma(32'h202, 1'b1, 2'b01, 32'hAABBCCDD, lat, rd);
      ref_store(32'h202, 2'b01, 32'hAABBCCDD);
      checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency got %0d want 3", lat); end
      checks++;
      if (wr_a_q.size() != 2 || wr_a_q[0] !== 32'h202 || wr_d_q[0] !== 8'hDD ||
          wr_a_q[1] !== 32'h203 || wr_d_q[1] !== 8'hCC) begin
         errors++;
         $display("FAIL sh_writes got %0d writes first %h/%h want (202,DD),(203,CC)",
                  wr_a_q.size(), (wr_a_q.size() > 0) ? wr_a_q[0] : 32'hx, (wr_d_q.size() > 0) ? wr_d_q[0] : 8'hx);
      end
      checks++; if (ram[16'h204] !== 8'h77) begin errors++; $display("FAIL sh_neighbour got %h want 77", ram[16'h204]); end
   endtask

   task automatic test_priority();
      int ma_lat, if_lat; logic [31:0] ma_rd, if_rd;
      ma_lat = -1; if_lat = -1; ma_rd = 0; if_rd = 0;
      ma_have_mem_access_task = 1'b1; ma_mem_access_addr = 32'h150;
      ma_mem_access_rw = 1'b0; ma_mem_access_size = 2'b00; ma_mem_access_data = 32'd0;
      if_have_fetch_task = 1'b1; if_fetch_addr = 32'h400;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (ma_mem_access_task_done && ma_lat < 0) begin
            ma_lat = c; ma_rd = ma_mem_access_data_out; ma_have_mem_access_task = 1'b0;
         end
         if (if_fetch_done) begin
            if_lat = c; if_rd = if_fetch_data; if_have_fetch_task = 1'b0;
            break;
         end
      end
      ma_have_mem_access_task = 1'b0; if_have_fetch_task = 1'b0;
      tick();
      checks++; if (ma_lat != 3) begin errors++; $display("FAIL prio_lb_latency got %0d want 3", ma_lat); end
      checks++; if (ma_rd !== exp_read(32'h150, 2'b00)) begin errors++; $display("FAIL prio_lb_data got %h want %h", ma_rd, exp_read(32'h150, 2'b00)); end
      checks++; if (if_lat != 10) begin errors++; $display("FAIL prio_fetch_latency got %0d want 10", if_lat); end
      checks++; if (if_rd !== exp_read(32'h400, 2'b10)) begin errors++; $display("FAIL prio_fetch_data got %h want %h", if_rd, exp_read(32'h400, 2'b10)); end
   endtask

   task automatic test_flush_fetch();
      int lat; logic seen; logic [31:0] rd;
      seen = 1'b0; lat = -1; rd = 0;
      if_have_fetch_task = 1'b1; if_fetch_addr = 32'h600;
      tick(); seen |= if_fetch_done;
      tick(); seen |= if_fetch_done;
      tick(); seen |= if_fetch_done;
      flush_pipline = 1'b1; if_have_fetch_task = 1'b0;
      tick(); seen |= if_fetch_done;
      flush_pipline = 1'b0; if_have_fetch_task = 1'b1; if_fetch_addr = 32'h700;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (if_fetch_done) begin lat = c; rd = if_fetch_data; break; end
      end
      if_have_fetch_task = 1'b0;
      tick();
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_fetch_done got done=%b want 0", seen); end
      checks++; if (lat != 6) begin errors++; $display("FAIL flush_refetch_latency got %0d want 6", lat); end
      checks++; if (rd !== exp_read(32'h700, 2'b10)) begin errors++; $display("FAIL flush_refetch_data got %h want %h", rd, exp_read(32'h700, 2'b10)); end
   endtask

   task automatic test_flush_write();
      int lat; logic [31:0] d;
      d = $urandom; lat = -1;
      wr_a_q.delete(); wr_d_q.delete();
      ma_have_mem_access_task = 1'b1; ma_mem_access_addr = 32'h300;
      ma_mem_access_rw = 1'b1; ma_mem_access_size = 2'b10; ma_mem_access_data = d;
      for (int c = 1; c <= 30; c++) begin
         tick();
         flush_pipline = (c == 3);
         if (ma_mem_access_task_done) begin lat = c; break; end
      end
      flush_pipline = 1'b0; ma_have_mem_access_task = 1'b0;
      tick();
      commit_writes();
      ref_store(32'h300, 2'b10, d);
      checks++; if (lat != 5) begin errors++; $display("FAIL flush_sw_latency got %0d want 5", lat); end
      checks++; if (wr_a_q.size() != 4) begin errors++; $display("FAIL flush_sw_count got %0d want 4", wr_a_q.size()); end
      checks++; if (exp_read(32'h300, 2'b10) !== {ram[16'h303], ram[16'h302], ram[16'h301], ram[16'h300]})
         begin errors++; $display("FAIL flush_sw_mem got %h want %h", {ram[16'h303], ram[16'h302], ram[16'h301], ram[16'h300]}, d); end
   endtask

   task automatic test_io_stall();
      int lat; logic wrs [1:5];
      lat = -1;
      for (int i = 1; i <= 5; i++) wrs[i] = 1'b0;
      wr_a_q.delete(); wr_d_q.delete();
      io_buffer_full = 1'b1;
      ma_have_mem_access_task = 1'b1; ma_mem_access_addr = 32'h30000;
      ma_mem_access_rw = 1'b1; ma_mem_access_size = 2'b00; ma_mem_access_data = 32'h5A;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c >= 4) io_buffer_full = 1'b0;
         #1;
         if (c <= 5) wrs[c] = mem_wr;
         if (ma_mem_access_task_done) begin lat = c; break; end
      end
      ma_have_mem_access_task = 1'b0;
      tick();
      commit_writes();
      ref_store(32'h30000, 2'b00, 32'h5A);
      checks++; if (wrs[1] | wrs[2] | wrs[3]) begin errors++; $display("FAIL io_stall_wr got %b%b%b want 000", wrs[1], wrs[2], wrs[3]); end
      checks++; if (wrs[4] !== 1'b1) begin errors++; $display("FAIL io_release_wr got %b want 1", wrs[4]); end
      checks++; if (lat != 5) begin errors++; $display("FAIL io_latency got %0d want 5", lat); end
      checks++;
      if (wr_a_q.size() != 1 || wr_a_q[0] !== 32'h30000 || wr_d_q[0] !== 8'h5A) begin
         errors++; $display("FAIL io_write got %0d writes want one (30000,5A)", wr_a_q.size());
      end
   endtask

   task automatic test_rdy();
      int lat; logic [31:0] rd; logic after;
      lat = -1; rd = 0;
      ram[16'h100] = 8'h11; ram[16'h101] = 8'h22; ram[16'h102] = 8'h33; ram[16'h103] = 8'h44;
      ref_mem[16'h100] = 8'h11; ref_mem[16'h101] = 8'h22; ref_mem[16'h102] = 8'h33; ref_mem[16'h103] = 8'h44;
      ma_have_mem_access_task = 1'b1; ma_mem_access_addr = 32'h100;
      ma_mem_access_rw = 1'b0; ma_mem_access_size = 2'b10;
      for (int c = 1; c <= 40; c++) begin
         tick();
         rdy_in = !(c == 3 || c == 4);
         if (ma_mem_access_task_done) begin lat = c; rd = ma_mem_access_data_out; break; end
      end
      rdy_in = 1'b1; ma_have_mem_access_task = 1'b0;
      tick();
      after = ma_mem_access_task_done;
      checks++; if (lat < 0) begin errors++; $display("FAIL rdy_timeout got no done want done"); end
      checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL rdy_data got %h want 44332211", rd); end
      checks++; if (after !== 1'b0) begin errors++; $display("FAIL rdy_pulse_width got %b want 0", after); end
   endtask

   task automatic test_random();
      int lat, n; logic [31:0] a, d, rd, want, ai, sh; logic rw; logic [1:0] sz;
      for (int it = 0; it < 24; it++) begin
         a  = (it == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 32'h7FFF);
         sz = (it == 0) ? 2'b10 : 2'($urandom_range(0, 3));
         rw = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         d  = $urandom;
         n  = nbytes(sz);
         want = exp_read(a, sz);
         do_ma(a, rw, sz, d, lat, rd);
         checks++;
         if (lat != (rw ? n + 1 : n + 2)) begin
            errors++; $display("FAIL rand_latency it %0d got %0d want %0d", it, lat, rw ? n + 1 : n + 2);
         end
         if (!rw) begin
            checks++;
            if (rd !== want) begin errors++; $display("FAIL rand_read it %0d addr %h got %h want %h", it, a, rd, want); end
         end else begin
            checks++;
            if (wr_a_q.size() != n) begin
               errors++; $display("FAIL rand_wcount it %0d got %0d want %0d", it, wr_a_q.size(), n);
            end else begin
               for (int i = 0; i < n; i++) begin
                  ai = a + i; sh = d >> (8 * i);
                  checks++;
                  if (wr_a_q[i] !== ai || wr_d_q[i] !== sh[7:0]) begin
                     errors++;
                     $display("FAIL rand_wbyte it %0d byte %0d got %h/%h want %h/%h", it, i, wr_a_q[i], wr_d_q[i], ai, sh[7:0]);
                  end
               end
            end
            ref_store(a, sz, d);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      seen = 1'b0;
      wr_a_q.delete(); wr_d_q.delete();
      ma_have_mem_access_task = 1'b1; ma_mem_access_addr = 32'h380;
      ma_mem_access_rw = 1'b1; ma_mem_access_size = 2'b10; ma_mem_access_data = 32'h12345678;
      tick(); tick();
      rst_in = 1'b1; ma_have_mem_access_task = 1'b0;
      tick();
      checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL midrst_mem_a got %h want 0", mem_a); end
      checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL midrst_mem_dout got %h want 0", mem_dout); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL midrst_mem_wr got %b want 0", mem_wr); end
      checks++; if (ma_mem_access_task_done !== 1'b0 || ma_mem_access_data_out !== 32'd0)
         begin errors++; $display("FAIL midrst_ma got %b/%h want 0/0", ma_mem_access_task_done, ma_mem_access_data_out); end
      rst_in = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         seen |= ma_mem_access_task_done | mem_wr;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_activity got %b want 0", seen); end
   endtask

   initial begin
      logic [7:0] v;
      rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0; io_buffer_full = 1'b0;
      ma_have_mem_access_task = 1'b0; ma_mem_access_addr = 32'd0; ma_mem_access_rw = 1'b0;
      ma_mem_access_size = 2'b00; ma_mem_access_data = 32'd0;
      if_have_fetch_task = 1'b0; if_fetch_addr = 32'd0;
      for (int i = 0; i < 65536; i++) begin
         v = 8'($urandom);
         ram[i] = v; ref_mem[i] = v;
      end
      test_reset();
      test_lw();
      test_sh();
      test_priority();
      test_flush_fetch();
      test_flush_write();
      test_io_stall();
      test_rdy();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule
